// File: rtl/apb_pkg.sv
// Shared types and helpers for the APB wait-state completer: FSM encoding,
// wait-count ceiling and the address decode check.
package apb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DONE = 2'd2
    } apb_state_e;

    localparam int APB_MAX_WAIT = 15;

    // True when addr lands on a word boundary inside [base, base + depth*nbytes).
    function automatic logic apb_addr_ok(input logic [63:0] addr,
                                         input logic [63:0] base,
                                         input logic [63:0] depth,
                                         input logic [63:0] nbytes);
        logic [63:0] lim;
        lim = base + depth * nbytes;
        return (addr >= base) && (addr < lim) && ((addr & (nbytes - 64'd1)) == 64'd0);
    endfunction

endpackage

// File: rtl/apb_wait_ctr.sv
// 4-bit wait-state counter: loads a count, decrements on request and stops at
// zero instead of wrapping.
module apb_wait_ctr (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] load_val,
    input  logic       dec,
    output logic [3:0] cnt,
    output logic       zero,
    output logic       last
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= 4'd0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
        end
    end

    assign zero = (cnt == 4'd0);
    assign last = (cnt == 4'd1);

endmodule

// File: rtl/apb_wait_slave.sv
// APB3 completer with a DEPTH-word register file and a programmable number of
// wait states per access; decode errors complete with zero waits.
module apb_wait_slave
    import apb_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter int              DEPTH     = 16,
    parameter longint unsigned BASE_ADDR = 0,
    parameter int              RD_WAIT   = 3,
    parameter int              WR_WAIT   = 1
) (
    input  logic                pclk,
    input  logic                preset,
    input  logic                pselx,
    input  logic                penable,
    input  logic                pwrite,
    input  logic [ADDR_W-1:0]   paddr,
    input  logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W/8-1:0] pstrb,
    input  logic                wait_ovr_en,
    input  logic [3:0]          wait_ovr,
    output logic [DATA_W-1:0]   prdata,
    output logic                pready,
    output logic                pslverr,
    output apb_state_e          dbg_state
);

    localparam int BYTES = DATA_W / 8;
    localparam int IDX_W = $clog2(DEPTH);
    localparam int OFF_W = $clog2(BYTES);
    localparam logic [3:0] RD_N = 4'(RD_WAIT > APB_MAX_WAIT ? APB_MAX_WAIT : RD_WAIT);
    localparam logic [3:0] WR_N = 4'(WR_WAIT > APB_MAX_WAIT ? APB_MAX_WAIT : WR_WAIT);

    apb_state_e state_q, state_d;

    logic [ADDR_W-1:0] addr_q;
    logic              write_q;
    logic [DATA_W-1:0] wdata_q;
    logic [BYTES-1:0]  strb_q;
    logic [DATA_W-1:0] regs [DEPTH];

    logic       setup, raise, finish, dec;
    logic       addr_err;
    logic [3:0] n_sel;
    logic [3:0] ctr_cnt;
    logic       ctr_zero, ctr_last;
    logic       cur_write;
    logic [IDX_W-1:0] cur_idx, idx_q;

    function automatic logic [IDX_W-1:0] word_idx(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] rel;
        rel = a - ADDR_W'(BASE_ADDR);
        return IDX_W'(rel >> OFF_W);
    endfunction

    assign addr_err  = !apb_addr_ok(64'(paddr), 64'(BASE_ADDR), 64'(DEPTH), 64'(BYTES));
    assign n_sel     = wait_ovr_en ? wait_ovr : (pwrite ? WR_N : RD_N);
    assign idx_q     = word_idx(addr_q);
    // On the setup edge the live bus is the only source; later the latched copy is.
    assign cur_idx   = setup ? word_idx(paddr) : idx_q;
    assign cur_write = setup ? pwrite : write_q;
    assign dbg_state = state_q;

    apb_wait_ctr u_ctr (
        .clk      (pclk),
        .rst      (preset),
        .load     (setup),
        .load_val (n_sel),
        .dec      (dec),
        .cnt      (ctr_cnt),
        .zero     (ctr_zero),
        .last     (ctr_last)
    );

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        setup   = 1'b0;
        raise   = 1'b0;
        finish  = 1'b0;
        dec     = 1'b0;
        case (state_q)
            IDLE: begin
                if (pselx && !penable) begin
                    setup = 1'b1;
                    if (addr_err || (n_sel == 4'd0)) begin
                        state_d = DONE;
                        raise   = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!pselx) begin
                    state_d = IDLE;
                end else if (penable) begin
                    dec = 1'b1;
                    if (ctr_last || ctr_zero) begin
                        state_d = DONE;
                        raise   = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                finish  = pselx && penable;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            addr_q  <= '0;
            write_q <= 1'b0;
            wdata_q <= '0;
            strb_q  <= '0;
        end else if (setup) begin
            addr_q  <= paddr;
            write_q <= pwrite;
            wdata_q <= pwdata;
            strb_q  <= pstrb;
        end
    end

    // pready lives for exactly the DONE cycle; errors only arise on the setup edge.
    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            pready  <= 1'b0;
            pslverr <= 1'b0;
            prdata  <= '0;
        end else begin
            pready  <= raise;
            pslverr <= raise && setup && addr_err;
            prdata  <= (raise && !cur_write && !(setup && addr_err)) ? regs[cur_idx] : '0;
        end
    end

    always_ff @(posedge pclk or posedge preset) begin
        if (preset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
        end else if (finish && write_q && !pslverr) begin
            for (int b = 0; b < BYTES; b++) begin
                if (strb_q[b]) regs[idx_q][b*8 +: 8] <= wdata_q[b*8 +: 8];
            end
        end
    end

endmodule
